// File: rtl/mic_sample_dma.sv
// mic_sample_dma: single-channel Avalon-MM write-master DMA for the mic array.
// Each read_ready strobe captures one 32-bit sample word. That word is then
// written to base + 4*count. After number_samples words the block raises
// FINISHED and holds it until start is dropped.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   AM_*                  Avalon-MM write master (single-word bursts, all bytes)
//   mic_data, read_ready  sample word and its one-cycle valid strobe
//   select                source-select code to the upstream sample mux
//   start                 level enable; latches start_address / number_samples
//   start_address         destination base byte address
//   number_samples        number of words to write
//   FINISHED              capture complete
module mic_sample_dma #(
    parameter logic [2:0] SOURCE_SEL = 3'b001
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] AM_ADDR,
    output logic [2:0]  AM_BURSTCOUNT,
    output logic        AM_WRITE,
    output logic [31:0] AM_WRITEDATA,
    output logic [3:0]  AM_BYTEENABLE,
    input  logic        AM_WAITREQUEST,
    input  logic [31:0] mic_data,
    output logic [2:0]  select,
    input  logic        start,
    input  logic        read_ready,
    input  logic [31:0] start_address,
    input  logic [31:0] number_samples,
    output logic        FINISHED
);

    typedef enum logic [1:0] {IDLE, WAIT_SAMPLE, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] base, total, count, data;
    logic        wr_done;
    logic        last;

    assign wr_done = (state == WRITE) && !AM_WAITREQUEST;
    assign last    = (count + 32'd1) == total;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (start) state_nxt = (number_samples == 32'd0) ? DONE : WAIT_SAMPLE;
            WAIT_SAMPLE: if (read_ready) state_nxt = WRITE;
                         else if (!start) state_nxt = IDLE;
            // start=0 only takes effect once the pending write has been accepted.
            WRITE:       if (!AM_WAITREQUEST) begin
                             if (last)        state_nxt = DONE;
                             else if (!start) state_nxt = IDLE;
                             else             state_nxt = WAIT_SAMPLE;
                         end
            DONE:        if (!start) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            base  <= '0;
            total <= '0;
            count <= '0;
            data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                base  <= start_address;
                total <= number_samples;
                count <= '0;
            end
            // Strobes outside WAIT_SAMPLE are dropped: there is no sample buffer.
            if (state == WAIT_SAMPLE && read_ready) data <= mic_data;
            if (wr_done) count <= count + 32'd1;
        end
    end

    // Outputs are decoded from registers only, so there is no input-to-output path.
    // The address wraps modulo 2^32.
    assign AM_WRITE      = (state == WRITE);
    assign AM_ADDR       = AM_WRITE ? (base + {count[29:0], 2'b00}) : 32'd0;
    assign AM_WRITEDATA  = data;
    assign AM_BURSTCOUNT = 3'd1;
    assign AM_BYTEENABLE = 4'hF;
    assign FINISHED      = (state == DONE);
    assign select        = (state == IDLE) ? 3'b000 : SOURCE_SEL;

endmodule

// File: tb/tb_mic_sample_dma.sv
// Randomized bench for mic_sample_dma. Drivers push each expected write
// (address, data) into a scoreboard queue. A negedge monitor compares every
// cycle in which AM_WRITE is high against the queue head. The head is popped
// when the transfer is accepted, so repeated compares during a stall check
// that address and data stay stable.
module tb_mic_sample_dma;
    localparam logic [2:0] SS = 3'b001;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] AM_ADDR;
    logic [2:0]  AM_BURSTCOUNT;
    logic        AM_WRITE;
    logic [31:0] AM_WRITEDATA;
    logic [3:0]  AM_BYTEENABLE;
    logic        AM_WAITREQUEST;
    logic [31:0] mic_data;
    logic [2:0]  select;
    logic        start;
    logic        read_ready;
    logic [31:0] start_address;
    logic [31:0] number_samples;
    logic        FINISHED;

    mic_sample_dma #(.SOURCE_SEL(SS)) dut (
        .CLK(CLK), .RESET(RESET),
        .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_WRITE(AM_WRITE),
        .AM_WRITEDATA(AM_WRITEDATA), .AM_BYTEENABLE(AM_BYTEENABLE),
        .AM_WAITREQUEST(AM_WAITREQUEST), .mic_data(mic_data), .select(select),
        .start(start), .read_ready(read_ready), .start_address(start_address),
        .number_samples(number_samples), .FINISHED(FINISHED)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write cycle must match the scoreboard head.
    always @(negedge CLK) begin
        if (RESET !== 1'b1 && AM_WRITE === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", AM_ADDR, AM_WRITEDATA);
            end else begin
                chk("wr_addr",  AM_ADDR,      sb[0].addr);
                chk("wr_data",  AM_WRITEDATA, sb[0].data);
                chk("wr_be",    {28'd0, AM_BYTEENABLE}, 32'hF);
                chk("wr_burst", {29'd0, AM_BURSTCOUNT}, 32'd1);
                if (AM_WAITREQUEST === 1'b0) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // One sample strobe followed by a write that stalls for 'stall' cycles.
    // drop: a second strobe arrives mid-stall and must be ignored.
    // stop: start drops mid-stall, which must not abort the write.
    task automatic sample(input logic [31:0] addr, input int stall, input bit drop, input bit stop);
        logic [31:0] d;
        d = $urandom;
        mic_data = d; read_ready = 1'b1;
        sb.push_back('{addr, d});
        AM_WAITREQUEST = (stall > 0);
        tick();                                  // strobe accepted, AM_WRITE from here
        read_ready = 1'b0; mic_data = $urandom;
        for (int i = 0; i < stall; i++) begin
            read_ready = drop && (i == 0);
            if (stop && i == 0) start = 1'b0;
            tick();
            read_ready = 1'b0;
        end
        AM_WAITREQUEST = 1'b0;
        tick();                                  // transfer accepted
    endtask

    // Full capture. st < 0 picks a random stall per write.
    task automatic run(input logic [31:0] base, input int n, input int st, input bit drop_en);
        logic [31:0] a;
        int s;
        start_address = base; number_samples = n; start = 1'b1;
        tick();
        if (n == 0) begin
            chk("zero_finished", {31'd0, FINISHED}, 32'd1);
            repeat (3) begin
                tick();
                chk("zero_hold", {31'd0, FINISHED}, 32'd1);
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    chk("wait_select", {29'd0, select}, {29'd0, SS});
                    chk("wait_finished", {31'd0, FINISHED}, 32'd0);
                    tick();
                end
                a = base + 32'(k * 4);
                s = (st < 0) ? int'($urandom_range(0, 3)) : st;
                sample(a, s, drop_en && ($urandom_range(0, 1) == 1), 1'b0);
            end
            chk("done_finished", {31'd0, FINISHED}, 32'd1);
            chk("done_select",   {29'd0, select},   {29'd0, SS});
            repeat ($urandom_range(1, 3)) begin
                tick();
                chk("done_hold", {31'd0, FINISHED}, 32'd1);
            end
        end
        start = 1'b0;
        tick();
        chk("idle_finished", {31'd0, FINISHED}, 32'd0);
        chk("idle_select",   {29'd0, select},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; AM_WAITREQUEST = 1'b0; mic_data = '0; start = 1'b0;
        read_ready = 1'b0; start_address = '0; number_samples = '0;
        repeat (3) tick();
        RESET = 1'b0;
        chk("rst_write",    {31'd0, AM_WRITE}, 32'd0);
        chk("rst_addr",     AM_ADDR,      32'd0);
        chk("rst_data",     AM_WRITEDATA, 32'd0);
        chk("rst_finished", {31'd0, FINISHED}, 32'd0);
        chk("rst_select",   {29'd0, select},   32'd0);
        tick();

        run(32'h1000_0000, 3, 0, 1'b0);          // basic back-to-back
        run(32'h2000_0100, 2, 5, 1'b0);          // long stall on every write
        run(32'h0000_0000, 0, 0, 1'b0);          // zero length
        run(32'h3000_0000, 4, 2, 1'b1);          // dropped strobes during stalls
        run(32'hFFFF_FFFC, 2, -1, 1'b0);         // address wrap
        for (int r = 0; r < 6; r++)
            run($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 6)), -1, 1'b1);

        // Abort while waiting for a sample.
        start_address = 32'h4000_0000; number_samples = 4; start = 1'b1;
        tick();
        chk("abort_wait_select", {29'd0, select}, {29'd0, SS});
        start = 1'b0;
        tick();
        chk("abort_select",   {29'd0, select},   32'd0);
        chk("abort_finished", {31'd0, FINISHED}, 32'd0);

        // start drops during a stalled write: the write still completes, then IDLE.
        start_address = 32'h5000_0000; number_samples = 3; start = 1'b1;
        tick();
        sample(32'h5000_0000, 2, 1'b0, 1'b1);
        chk("stop_mid_select",   {29'd0, select},   32'd0);
        chk("stop_mid_finished", {31'd0, FINISHED}, 32'd0);
        tick();
        chk("stop_mid_nowrite",  {31'd0, AM_WRITE}, 32'd0);

        // Reset while a write is stalled.
        start_address = 32'h6000_0000; number_samples = 3; start = 1'b1;
        tick();
        mic_data = 32'hDEAD_BEEF; read_ready = 1'b1; AM_WAITREQUEST = 1'b1;
        sb.push_back('{32'h6000_0000, 32'hDEAD_BEEF});
        tick();
        read_ready = 1'b0;
        RESET = 1'b1;
        tick();
        chk("midrst_write",    {31'd0, AM_WRITE}, 32'd0);
        chk("midrst_finished", {31'd0, FINISHED}, 32'd0);
        chk("midrst_select",   {29'd0, select},   32'd0);
        chk("midrst_addr",     AM_ADDR, 32'd0);
        sb.delete();
        RESET = 1'b0; AM_WAITREQUEST = 1'b0; start = 1'b0;
        tick();
        chk("post_rst_select", {29'd0, select}, 32'd0);
        repeat (2) tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
